// File: rtl/fx2_sched_pkg.sv
// Shared types and constants for the FX2LP slave-FIFO bus scheduler.
package fx2_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_SEL = 3'd1,
      ST_READ   = 3'd2,
      ST_WR_SEL = 3'd3,
      ST_WRITE  = 3'd4,
      ST_PKTEND = 3'd5
   } fx2_state_t;

   localparam logic [1:0] FADDR_EP2 = 2'b00;
   localparam logic [1:0] FADDR_EP6 = 2'b10;
   localparam int PKT_WORDS_DEFAULT = 256;

endpackage

// File: rtl/fx2_pktend_timer.sv
// Tracks the EP6 partial-packet word count and decides when a short packet
// has to be committed (explicit flush or tx idle timeout).
module fx2_pktend_timer
   import fx2_sched_pkg::*;
#(
   parameter int PKT_WORDS    = PKT_WORDS_DEFAULT,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tx_word,
   input  logic i_tx_valid,
   input  logic i_tx_flush,
   input  logic i_pktend_done,
   output logic o_commit_pending
);

   localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   logic [PW-1:0] r_part;
   logic [IW-1:0] r_idle;
   logic          r_flush;
   logic          w_part_nz;
   logic          w_timeout;
   logic          w_wrap;

   assign w_part_nz = (r_part != '0);
   assign w_timeout = (r_idle == IW'(IDLE_TIMEOUT));
   assign w_wrap    = i_tx_word && (r_part == PW'(PKT_WORDS - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_part  <= '0;
         r_idle  <= '0;
         r_flush <= 1'b0;
      end else begin
         if (i_pktend_done || w_wrap)
            r_part <= '0;
         else if (i_tx_word)
            r_part <= r_part + 1'b1;

         if (i_tx_valid)
            r_idle <= '0;
         else if (!w_timeout)
            r_idle <= r_idle + 1'b1;

         // A full packet commits itself in the FX2, so a pending flush dies with it.
         if (i_pktend_done || w_wrap)
            r_flush <= 1'b0;
         else if (i_tx_flush && w_part_nz)
            r_flush <= 1'b1;
      end
   end

   assign o_commit_pending = w_part_nz && (r_flush || w_timeout);

endmodule

// File: rtl/fx2_slavefifo_sched.sv
// Time-shares the FX2LP slave-FIFO bus between EP2 OUT reads and EP6 IN writes,
// with address settle turnaround, bounded bursts and short-packet commit.
module fx2_slavefifo_sched
   import fx2_sched_pkg::*;
#(
   parameter int TURN_CYC     = 2,
   parameter int MAX_BURST    = 256,
   parameter int PKT_WORDS    = PKT_WORDS_DEFAULT,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flag_ef,
   input  logic        flag_ff,
   input  logic [15:0] fdata_i,
   output logic [15:0] fdata_o,
   output logic        fdata_oe,
   output logic [1:0]  faddr,
   output logic        slrd,
   output logic        sloe,
   output logic        slwr,
   output logic        pktend,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic [15:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic        tx_flush,
   output fx2_state_t  o_dbg_state
);

   localparam int TW = $clog2(TURN_CYC + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   fx2_state_t    r_state;
   fx2_state_t    w_next;
   logic          r_last_tx;
   logic          r_sel_pe;
   logic [TW-1:0] r_turn;
   logic [BW-1:0] r_burst;

   logic w_rx_req;
   logic w_tx_req;
   logic w_pe_req;
   logic w_commit_pending;
   logic w_turn_done;
   logic w_burst_last;
   logic w_in_sel;
   logic w_strobe;

   assign w_rx_req     = flag_ef & rx_ready;
   assign w_tx_req     = flag_ff & tx_valid;
   assign w_pe_req     = w_commit_pending & flag_ff;
   assign w_turn_done  = (r_turn == TW'(TURN_CYC - 1));
   assign w_burst_last = (r_burst == BW'(MAX_BURST - 1));
   assign w_in_sel     = (r_state == ST_RD_SEL) || (r_state == ST_WR_SEL);
   assign w_strobe     = ~slrd | ~slwr;

   always_comb begin
      w_next   = r_state;
      faddr    = FADDR_EP2;
      slrd     = 1'b1;
      sloe     = 1'b1;
      slwr     = 1'b1;
      pktend   = 1'b1;
      fdata_oe = 1'b0;
      fdata_o  = '0;
      tx_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pe_req)
               w_next = ST_WR_SEL;
            else if (w_rx_req && w_tx_req)
               w_next = r_last_tx ? ST_RD_SEL : ST_WR_SEL;
            else if (w_rx_req)
               w_next = ST_RD_SEL;
            else if (w_tx_req)
               w_next = ST_WR_SEL;
         end
         ST_RD_SEL: begin
            if (w_turn_done)
               w_next = ST_READ;
         end
         ST_READ: begin
            sloe = 1'b0;
            slrd = ~w_rx_req;
            if (!w_rx_req || w_burst_last)
               w_next = ST_IDLE;
         end
         ST_WR_SEL: begin
            faddr = FADDR_EP6;
            if (w_turn_done)
               w_next = r_sel_pe ? ST_PKTEND : ST_WRITE;
         end
         ST_WRITE: begin
            faddr    = FADDR_EP6;
            fdata_oe = 1'b1;
            fdata_o  = tx_data;
            slwr     = ~w_tx_req;
            tx_ready = w_tx_req;
            if (!w_tx_req || w_burst_last)
               w_next = ST_IDLE;
         end
         ST_PKTEND: begin
            faddr  = FADDR_EP6;
            pktend = 1'b0;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_last_tx <= 1'b1;
         r_sel_pe  <= 1'b0;
         r_turn    <= '0;
         r_burst   <= '0;
      end else begin
         r_state <= w_next;
         // Commit grants do not take part in the rx/tx fairness rotation.
         if (r_state == ST_IDLE) begin
            r_sel_pe <= w_pe_req;
            if (!w_pe_req && (w_next == ST_RD_SEL))
               r_last_tx <= 1'b0;
            else if (!w_pe_req && (w_next == ST_WR_SEL))
               r_last_tx <= 1'b1;
         end
         if (w_in_sel && (w_next == r_state))
            r_turn <= r_turn + 1'b1;
         else
            r_turn <= '0;
         if (r_state == ST_IDLE)
            r_burst <= '0;
         else if (w_strobe)
            r_burst <= r_burst + 1'b1;
      end
   end

   assign rx_data     = fdata_i;
   assign rx_valid    = ~slrd;
   assign o_dbg_state = r_state;

   fx2_pktend_timer #(
      .PKT_WORDS    (PKT_WORDS),
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) u_pktend_timer (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_tx_word        (~slwr),
      .i_tx_valid       (tx_valid),
      .i_tx_flush       (tx_flush),
      .i_pktend_done    (r_state == ST_PKTEND),
      .o_commit_pending (w_commit_pending)
   );

endmodule

// File: tb/tb_fx2_slavefifo_sched.sv
// Directed bench: FX2 EP2/EP6 behavioural model, bus monitor and scoreboard.
module tb_fx2_slavefifo_sched;
   import fx2_sched_pkg::*;

   localparam int TURN_CYC     = 2;
   localparam int MAX_BURST    = 256;
   localparam int PKT_WORDS    = 256;
   localparam int IDLE_TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        flag_ef, flag_ff;
   logic [15:0] fdata_i, fdata_o, rx_data, tx_data;
   logic        fdata_oe, slrd, sloe, slwr, pktend;
   logic [1:0]  faddr;
   logic        rx_valid, rx_ready, tx_valid, tx_ready, tx_flush;
   fx2_state_t  dbg_state;

   int ep2_total = 0, ep2_done = 0, tx_total = 0, tx_done = 0;
   logic ep6_block;

   int n_checks = 0, n_fail = 0;
   logic [15:0] exp_q[$];
   logic [15:0] rx_obs_q[$];
   logic [15:0] wr_obs_q[$];
   int rd_runs[$], wr_runs[$];
   int rd_run = 0, wr_run = 0, ovl = 0, pk_cnt = 0, pk_bad = 0, wr_bad = 0;
   int rx_idx = 0, wr_idx = 0;

   fx2_slavefifo_sched #(
      .TURN_CYC(TURN_CYC), .MAX_BURST(MAX_BURST),
      .PKT_WORDS(PKT_WORDS), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .flag_ef(flag_ef), .flag_ff(flag_ff),
      .fdata_i(fdata_i), .fdata_o(fdata_o), .fdata_oe(fdata_oe), .faddr(faddr),
      .slrd(slrd), .sloe(sloe), .slwr(slwr), .pktend(pktend),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_flush(tx_flush), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // FX2 endpoint and local tx source models
   assign flag_ef  = (ep2_done != ep2_total);
   assign flag_ff  = ~ep6_block;
   assign fdata_i  = 16'hA000 + 16'(ep2_done);
   assign tx_valid = (tx_done != tx_total);
   assign tx_data  = 16'h5000 + 16'(tx_done);

   always @(posedge clk) begin
      if (!slrd) ep2_done <= ep2_done + 1;
      if (tx_ready) tx_done <= tx_done + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) rx_obs_q.push_back(rx_data);
         if (!slrd) rd_run++;
         else if (rd_run != 0) begin rd_runs.push_back(rd_run); rd_run = 0; end
         if (!slwr) begin wr_run++; wr_obs_q.push_back(fdata_o); end
         else if (wr_run != 0) begin wr_runs.push_back(wr_run); wr_run = 0; end
         if ((!slwr && (!tx_ready || !fdata_oe)) || (slwr && tx_ready)) wr_bad++;
         if (!sloe && fdata_oe) ovl++;
         if (!pktend) begin
            pk_cnt++;
            if (faddr != FADDR_EP6 || !slwr) pk_bad++;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic load_rx(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(16'hA000 + 16'(ep2_total + i));
      ep2_total += n;
   endtask

   task automatic drain(input string tag, input int limit);
      int c;
      c = 0;
      while ((tx_done != tx_total || ep2_done != ep2_total) && c < limit) begin
         cycles(1);
         c++;
      end
      check_eq({tag, "_drain"}, 32'(c < limit), 32'd1);
   endtask

   task automatic check_data();
      logic [31:0] e;
      while (rx_idx < rx_obs_q.size()) begin
         e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
         check_eq("rx_data", 32'(rx_obs_q[rx_idx]), e);
         rx_idx++;
      end
      while (wr_idx < wr_obs_q.size()) begin
         check_eq("ep6_data", 32'(wr_obs_q[wr_idx]), 32'(16'h5000 + 16'(wr_idx)));
         wr_idx++;
      end
   endtask

   initial begin
      int rb, wb, pb, tb, lat, n, c;
      rst = 1'b1; rx_ready = 1'b1; ep6_block = 1'b0; tx_flush = 1'b0;
      cycles(3);
      check_eq("rst_faddr", 32'(faddr), 32'd0);
      check_eq("rst_strobes", {28'd0, slrd, sloe, slwr, pktend}, 32'hF);
      check_eq("rst_oe", 32'(fdata_oe), 32'd0);
      check_eq("rst_fdata_o", 32'(fdata_o), 32'd0);
      check_eq("rst_handshake", {30'd0, rx_valid, tx_ready}, 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      cycles(2);

      // 10-word read: first strobe TURN_CYC+1 edges after the request is seen
      rb = rd_runs.size();
      load_rx(10);
      lat = 0;
      do begin @(negedge clk); lat++; end while (slrd && lat < 20);
      check_eq("rx_first_strobe_lat", 32'(lat), 32'(TURN_CYC + 2));
      drain("rx10", 100);
      cycles(3);
      check_eq("rx10_run", 32'((rd_runs.size() > rb) ? rd_runs[rb] : -1), 32'd10);
      check_data();

      // both sides busy: bursts of MAX_BURST alternate, tx first after an rx grant
      rb = rd_runs.size(); wb = wr_runs.size(); pb = pk_cnt;
      load_rx(512);
      tx_total += 512;
      drain("alt", 3000);
      cycles(3);
      check_eq("alt_rd_bursts", 32'(rd_runs.size() - rb), 32'd2);
      check_eq("alt_wr_bursts", 32'(wr_runs.size() - wb), 32'd2);
      check_eq("alt_rd0", 32'((rd_runs.size() > rb) ? rd_runs[rb] : -1), 32'(MAX_BURST));
      check_eq("alt_wr1", 32'((wr_runs.size() > wb + 1) ? wr_runs[wb + 1] : -1), 32'(MAX_BURST));
      check_eq("alt_no_pktend", 32'(pk_cnt - pb), 32'd0);
      check_data();

      // exactly one packet then flush: nothing to commit
      wb = wr_runs.size(); pb = pk_cnt;
      tx_total += 256;
      drain("full_pkt", 600);
      tx_flush = 1'b1; cycles(1); tx_flush = 1'b0;
      cycles(40);
      check_eq("full_pkt_run", 32'((wr_runs.size() > wb) ? wr_runs[wb] : -1), 32'd256);
      check_eq("full_pkt_no_pktend", 32'(pk_cnt - pb), 32'd0);
      check_data();

      // 300 words leave 44 partial: committed after IDLE_TIMEOUT idle cycles
      wb = wr_runs.size(); pb = pk_cnt;
      tx_total += 300;
      c = 0;
      while (tx_done != tx_total && c < 1000) begin @(negedge clk); c++; end
      check_eq("part44_drain", 32'(c < 1000), 32'd1);
      n = 1;
      while (pktend && n < 3000) begin @(negedge clk); n++; end
      check_eq("part44_pktend_lat", 32'(n), 32'(IDLE_TIMEOUT + TURN_CYC + 2));
      check_eq("part44_faddr", 32'(faddr), 32'(FADDR_EP6));
      cycles(20);
      check_eq("part44_pktend_once", 32'(pk_cnt - pb), 32'd1);
      check_eq("part44_tail_run", 32'((wr_runs.size() > wb + 1) ? wr_runs[wb + 1] : -1), 32'd44);
      check_data();

      // flag_ff drops after word 5 of a 20-word write
      pb = pk_cnt; tb = tx_done; wb = wr_obs_q.size();
      tx_total += 20;
      c = 0;
      while ((tx_done - tb) < 5 && c < 100) begin cycles(1); c++; end
      ep6_block = 1'b1;
      #1;
      check_eq("ffdrop_slwr", 32'(slwr), 32'd1);
      check_eq("ffdrop_tx_ready", 32'(tx_ready), 32'd0);
      cycles(4);
      check_eq("ffdrop_words", 32'(tx_done - tb), 32'd5);
      check_eq("ffdrop_state", 32'(dbg_state), 32'(ST_IDLE));
      ep6_block = 1'b0;
      drain("ffdrop", 200);
      check_eq("ffdrop_total", 32'(wr_obs_q.size() - wb), 32'd20);
      tx_flush = 1'b1; cycles(1); tx_flush = 1'b0;
      cycles(20);
      check_eq("flush_pktend_once", 32'(pk_cnt - pb), 32'd1);
      check_data();

      // asynchronous reset mid-READ, then rx wins the first contested grant
      rb = ep2_done;
      load_rx(100);
      c = 0;
      while ((ep2_done - rb) < 3 && c < 100) begin cycles(1); c++; end
      rst = 1'b1;
      #1;
      check_eq("arst_rd_strobes", {30'd0, slrd, sloe}, 32'd3);
      check_eq("arst_faddr", 32'(faddr), 32'(FADDR_EP2));
      check_eq("arst_oe", 32'(fdata_oe), 32'd0);
      check_eq("arst_rx_valid", 32'(rx_valid), 32'd0);
      tx_total += 10;
      cycles(3);
      rst = 1'b0;
      c = 0;
      do begin @(negedge clk); c++; end while (slrd && slwr && c < 20);
      check_eq("arst_first_grant_rx", {30'd0, slrd, slwr}, 32'd1);
      drain("arst", 600);
      cycles(3);
      check_data();
      check_eq("rx_exp_empty", 32'(exp_q.size()), 32'd0);

      check_eq("sloe_oe_overlap", 32'(ovl), 32'd0);
      check_eq("pktend_bus_state", 32'(pk_bad), 32'd0);
      check_eq("slwr_tx_ready_pair", 32'(wr_bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
